fpu_normalizer: RTL and testbench

- Back end of the FPU add path.
- Takes the unnormalized sign, exponent and extended fraction produced by the adder stage.
- Normalizes iteratively, one left shift per cycle, then rounds to nearest-even.
- Packs an IEEE-754 word and hands it out over a valid/ready handshake.
- Denormals are flushed to zero.

---
 rtl/fpu_normalizer.sv | 163 ++++++++++++++++
 tb/tb_fpu_normalizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalizer.sv
// Back end of the FPU add path: iterative left-shift normalization (one bit per
// cycle), round-to-nearest-even, IEEE-754 packing, valid/ready result handoff.
module fpu_normalizer #(
  parameter int WIDTH  = 32,
  parameter int E      = 8,
  parameter int F      = 23,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_s,
  input  logic [E-1:0]      in_e,
  input  logic [F+OFFSET:0] in_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [2:0]        out_flags
);

  localparam int FW = F + OFFSET + 1;

  localparam logic [E-1:0]  E_MAX       = {E{1'b1}};
  localparam logic [E-1:0]  E_ZERO      = {E{1'b0}};
  localparam logic [E-1:0]  E_ONE       = {{(E-1){1'b0}}, 1'b1};
  localparam logic [F-1:0]  M_ZERO      = {F{1'b0}};
  localparam logic [FW-1:0] F_ONE       = {{(FW-1){1'b0}}, 1'b1};
  // Bits below the guard position; empty when OFFSET is 1.
  localparam logic [FW-1:0] STICKY_MASK = (F_ONE << (OFFSET - 1)) - F_ONE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic             s_reg, s_next;
  logic [E-1:0]     e_reg, e_next;
  logic [FW-1:0]    f_reg, f_next;
  logic             flush_zero_reg, flush_zero_next;
  logic             flush_inf_reg, flush_inf_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [2:0]       flags_reg, flags_next;

  logic [F-1:0]     mant;
  logic             guard_bit;
  logic             sticky_bit;
  logic             round_up;
  logic [F:0]       mant_sum;
  logic             rnd_carry;
  logic [E-1:0]     e_rnd;

  assign mant       = f_reg[FW-2:OFFSET];
  assign guard_bit  = f_reg[OFFSET-1];
  assign sticky_bit = |(f_reg & STICKY_MASK);
  assign round_up   = guard_bit & (sticky_bit | mant[0]);
  assign mant_sum   = {1'b0, mant} + {{F{1'b0}}, round_up};
  // A carry out leaves the low F bits at zero, which is the renormalized mantissa.
  assign rnd_carry  = mant_sum[F];
  assign e_rnd      = e_reg + {{(E-1){1'b0}}, rnd_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      s_reg          <= 1'b0;
      e_reg          <= '0;
      f_reg          <= '0;
      flush_zero_reg <= 1'b0;
      flush_inf_reg  <= 1'b0;
      result_reg     <= '0;
      flags_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      s_reg          <= s_next;
      e_reg          <= e_next;
      f_reg          <= f_next;
      flush_zero_reg <= flush_zero_next;
      flush_inf_reg  <= flush_inf_next;
      result_reg     <= result_next;
      flags_reg      <= flags_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    s_next          = s_reg;
    e_next          = e_reg;
    f_next          = f_reg;
    flush_zero_next = flush_zero_reg;
    flush_inf_next  = flush_inf_reg;
    result_next     = result_reg;
    flags_next      = flags_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          s_next          = in_s;
          e_next          = in_e;
          f_next          = in_f;
          flush_zero_next = (in_e == E_ZERO);
          flush_inf_next  = (in_e == E_MAX);
          state_next      = SHIFT;
        end
      end

      SHIFT: begin
        if (f_reg == '0) begin
          result_next = {s_reg, E_ZERO, M_ZERO};
          flags_next  = 3'b000;
          state_next  = DONE;
        end else if (flush_zero_reg) begin
          result_next = {s_reg, E_ZERO, M_ZERO};
          flags_next  = 3'b010;
          state_next  = DONE;
        end else if (flush_inf_reg) begin
          result_next = {s_reg, E_MAX, M_ZERO};
          flags_next  = 3'b100;
          state_next  = DONE;
        end else if (f_reg[FW-1]) begin
          state_next = ROUND;
        end else if (e_reg == E_ONE) begin
          // Would go denormal: flush to signed zero.
          result_next = {s_reg, E_ZERO, M_ZERO};
          flags_next  = 3'b011;
          state_next  = DONE;
        end else begin
          f_next = f_reg << 1;
          e_next = e_reg - E_ONE;
        end
      end

      ROUND: begin
        if (e_rnd == E_MAX) begin
          result_next = {s_reg, E_MAX, M_ZERO};
          flags_next  = 3'b101;
        end else begin
          result_next = {s_reg, e_rnd, mant_sum[F-1:0]};
          flags_next  = {2'b00, guard_bit | sticky_bit};
        end
        state_next = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_flags  = flags_reg;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Self-checking bench for fpu_normalizer: vector table through a scoreboard
// queue, plus backpressure and reset-mid-shift sequences.
module tb_fpu_normalizer;

  localparam int WIDTH   = 32;
  localparam int E       = 8;
  localparam int F       = 23;
  localparam int OFFSET  = 1;
  localparam int FW      = F + OFFSET + 1;
  localparam int MAX_LAT = 64;
  localparam int NVEC    = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_s;
  logic [E-1:0]     in_e;
  logic [FW-1:0]    in_f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_flags;

  typedef struct {
    logic             s;
    logic [E-1:0]     e;
    logic [FW-1:0]    f;
    logic [WIDTH-1:0] res;
    logic [2:0]       flags;
    int               lat;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [2:0]       flags;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[NVEC];
  int   n_checks = 0;
  int   n_errors = 0;

  fpu_normalizer #(
    .WIDTH (WIDTH),
    .E     (E),
    .F     (F),
    .OFFSET(OFFSET)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_f      (in_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required within %0d", lat, MAX_LAT);
    end
  endtask

  task automatic drive_and_accept(input logic s, input logic [E-1:0] e, input logic [FW-1:0] f);
    in_valid = 1'b1;
    in_s     = s;
    in_e     = e;
    in_f     = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string name);
    int   lat;
    exp_t want;
    check($sformatf("%s in_ready", name), 32'(in_ready), 32'd1);
    drive_and_accept(v.s, v.e, v.f);
    want.res   = v.res;
    want.flags = v.flags;
    sb_q.push_back(want);
    wait_valid(lat);
    check($sformatf("%s latency", name), 32'(lat), 32'(v.lat));
    want = sb_q.pop_front();
    check($sformatf("%s result", name), out_result, want.res);
    check($sformatf("%s flags", name), 32'(out_flags), 32'(want.flags));
    $display("op %s: s=%0d e=%0d f=0x%07h -> result 0x%08h flags %03b lat %0d",
             name, v.s, v.e, v.f, out_result, out_flags, lat);
    @(posedge clk);
    #1;
    check($sformatf("%s out_valid after consume", name), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t want;

    vecs[0]  = '{1'b0, 8'd128, 25'h1000000, 32'h40000000, 3'b000, 2};
    vecs[1]  = '{1'b0, 8'd128, 25'h0800000, 32'h3F800000, 3'b000, 3};
    vecs[2]  = '{1'b0, 8'd3,   25'h0000001, 32'h00000000, 3'b011, 3};
    vecs[3]  = '{1'b0, 8'd127, 25'h1000001, 32'h3F800000, 3'b001, 2};
    vecs[4]  = '{1'b0, 8'd127, 25'h1000003, 32'h3F800002, 3'b001, 2};
    vecs[5]  = '{1'b0, 8'd254, 25'h1FFFFFF, 32'h7F800000, 3'b101, 2};
    vecs[6]  = '{1'b1, 8'd128, 25'h0000000, 32'h80000000, 3'b000, 1};
    vecs[7]  = '{1'b1, 8'd0,   25'h1000000, 32'h80000000, 3'b010, 1};
    vecs[8]  = '{1'b0, 8'd255, 25'h1000000, 32'h7F800000, 3'b100, 1};
    vecs[9]  = '{1'b0, 8'd200, 25'h0000001, 32'h58000000, 3'b000, 26};
    vecs[10] = '{1'b1, 8'd130, 25'h1800000, 32'hC1400000, 3'b000, 2};
    vecs[11] = '{1'b0, 8'd127, 25'h1000002, 32'h3F800001, 3'b000, 2};
    vecs[12] = '{1'b0, 8'd127, 25'h17FFFFF, 32'h3FC00000, 3'b001, 2};
    vecs[13] = '{1'b0, 8'd2,   25'h0800000, 32'h00800000, 3'b000, 3};
    vecs[14] = '{1'b1, 8'd1,   25'h0800000, 32'h80000000, 3'b011, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_s      = 1'b0;
    in_e      = '0;
    in_f      = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'h0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready is low; new input ignored.
    out_ready = 1'b0;
    drive_and_accept(1'b0, 8'd128, 25'h0800000);
    want.res   = 32'h3F800000;
    want.flags = 3'b000;
    sb_q.push_back(want);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_s     = 1'b1;
      in_e     = 8'd130;
      in_f     = 25'h1800000;
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d result", i), out_result, sb_q[0].res);
      check($sformatf("bp%0d flags", i), 32'(out_flags), 32'(sb_q[0].flags));
      check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp held out_valid", 32'(out_valid), 32'd1);
    check("bp held result", out_result, sb_q[0].res);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    want = sb_q.pop_front();
    $display("op backpressure: held result 0x%08h flags %03b for 5 cycles", out_result, out_flags);
    @(posedge clk);
    #1;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release result kept", out_result, want.res);
    run_op(vecs[10], "after_bp");

    // Reset pulled during cycle T0+3 of a 16-shift normalization.
    drive_and_accept(1'b0, 8'd100, 25'h0000100);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre-reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", 32'(out_valid), 32'd0);
    check("mid-reset in_ready", 32'(in_ready), 32'd1);
    check("mid-reset out_result", out_result, 32'h0);
    check("mid-reset out_flags", 32'(out_flags), 32'd0);
    $display("op reset_mid_shift: out_valid %0d in_ready %0d result 0x%08h", out_valid, in_ready, out_result);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    run_op(vecs[4], "after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
